// File: rtl/tx_frame_controller.sv
// tx_frame_controller
// Sequences the 12-bit rotating serial transmit datapath ({parity, data, 2'b01},
// sent LSB first). Accepts one word per Valid/Ready handshake, strobes Load,
// then issues one ShiftOut per bit period, holds the stop level, reports Done.
// Abort cuts a frame short by flushing the remaining rotation at full speed.
//
// Optional build macro: TX_STOP2_EN -- STOP lasts two bit periods instead of one.
//
// Ports:
//   Clock_i, ResetN_i     clock (rising edge), async active-low reset
//   Data_i, OddParity_i   word and parity mode, sampled on accept
//   Valid_i / Ready_o     producer handshake (Ready only in IDLE)
//   Abort_i               request to cut the current frame short
//   TxData_o, Parity_o    latched word / parity mode to the datapath
//   Load_o, ShiftOut_o    one-cycle datapath strobes
//   Busy_o                high in every state except IDLE
//   Done_o, Aborted_o     one-cycle completion pulses
module tx_frame_controller #(
    parameter int DataLength   = 9,
    parameter int ClocksPerBit = 16,
    parameter int FrameShifts  = 12
) (
    input  logic                  Clock_i,
    input  logic                  ResetN_i,
    input  logic [DataLength-1:0] Data_i,
    input  logic                  OddParity_i,
    input  logic                  Valid_i,
    output logic                  Ready_o,
    input  logic                  Abort_i,
    output logic [DataLength-1:0] TxData_o,
    output logic                  Parity_o,
    output logic                  Load_o,
    output logic                  ShiftOut_o,
    output logic                  Busy_o,
    output logic                  Done_o,
    output logic                  Aborted_o
);

    localparam int BW = (ClocksPerBit > 1) ? $clog2(ClocksPerBit) : 1;
    localparam int SW = $clog2(FrameShifts + 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(ClocksPerBit - 1);
    localparam logic [SW-1:0] SH_FULL  = SW'(FrameShifts);
    localparam logic [SW-1:0] SH_PRE   = SW'(FrameShifts - 1);

    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, STOP, FLUSH} state_t;

    state_t                state_q, state_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [SW-1:0]         sh_q, sh_d;
    logic [DataLength-1:0] data_q, data_d;
    logic                  par_q, par_d;
`ifdef TX_STOP2_EN
    logic                  stop2_q, stop2_d;   // first stop bit already sent
`endif

    logic bit_last;
    assign bit_last = (bit_q == BIT_LAST);

    always_ff @(posedge Clock_i or negedge ResetN_i) begin
        if (!ResetN_i) begin
            state_q <= IDLE;
            bit_q   <= '0;
            sh_q    <= '0;
            data_q  <= '0;
            par_q   <= 1'b0;
`ifdef TX_STOP2_EN
            stop2_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            par_q   <= par_d;
`ifdef TX_STOP2_EN
            stop2_q <= stop2_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        sh_d       = sh_q;
        data_d     = data_q;
        par_d      = par_q;
`ifdef TX_STOP2_EN
        stop2_d    = stop2_q;
`endif
        Ready_o    = 1'b0;
        Load_o     = 1'b0;
        ShiftOut_o = 1'b0;
        Done_o     = 1'b0;
        Aborted_o  = 1'b0;

        case (state_q)
            IDLE: begin
                Ready_o = 1'b1;
                if (Valid_i) begin
                    data_d  = Data_i;
                    par_d   = OddParity_i;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                Load_o  = 1'b1;
                bit_d   = '0;
                sh_d    = '0;
                state_d = Abort_i ? FLUSH : SHIFT;
            end
            SHIFT: begin
                if (bit_last) begin
                    ShiftOut_o = 1'b1;
                    bit_d      = '0;
                    sh_d       = sh_q + SW'(1);
                end else begin
                    bit_d = bit_q + BW'(1);
                end
                // Abort wins over the move to STOP, even on the final shift;
                // FLUSH then sees a full count and reports Aborted at once.
                if (Abort_i) begin
                    state_d = FLUSH;
                end else if (bit_last && sh_q == SH_PRE) begin
                    state_d = STOP;
`ifdef TX_STOP2_EN
                    stop2_d = 1'b0;
`endif
                end
            end
            STOP: begin
                if (bit_last) begin
                    bit_d = '0;
`ifdef TX_STOP2_EN
                    if (!stop2_q) begin
                        stop2_d = 1'b1;
                    end else begin
                        Done_o  = 1'b1;
                        state_d = IDLE;
                    end
`else
                    Done_o  = 1'b1;
                    state_d = IDLE;
`endif
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            FLUSH: begin
                // Finish the rotation back-to-back so Tx ends on the idle bit.
                if (sh_q == SH_FULL) begin
                    Aborted_o = 1'b1;
                    state_d   = IDLE;
                end else begin
                    ShiftOut_o = 1'b1;
                    sh_d       = sh_q + SW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign Busy_o   = (state_q != IDLE);
    assign TxData_o = data_q;
    assign Parity_o = par_q;

endmodule
